// File: rtl/frame_read_sequencer.sv
// Frame read sequencer: vsync start-up, per-row hsync gap, then an
// active line of even/odd pixel-pair addresses with downstream back-pressure.
module frame_read_sequencer #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int START_DELAY  = 100,
  parameter int HSYNC_DELAY  = 160,
  parameter int ROW_WIDTH    = 10,
  parameter int COL_WIDTH    = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pixel_Ready,
  output logic                 vertical_Pulse,
  output logic                 horizontal_Pulse,
  output logic                 pixel_Valid,
  output logic [ROW_WIDTH-1:0] row,
  output logic [COL_WIDTH-1:0] column,
  output logic                 busy,
  output logic                 done_Flag
);

  localparam int DLY_MAX =
    (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
  localparam int DLY_W = $clog2(DLY_MAX + 1);

  localparam logic [DLY_W-1:0] VS_LAST =
    DLY_W'(START_DELAY - 1);
  localparam logic [DLY_W-1:0] HS_LAST =
    DLY_W'(HSYNC_DELAY - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST =
    ROW_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [COL_WIDTH-1:0] COL_LAST =
    COL_WIDTH'(IMAGE_WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_HSYNC,
    S_DATA,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic                 xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    row_d   = row_q;
    col_d   = col_q;
    xfer    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        dly_d = '0;
        if (start) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (dly_q == VS_LAST) begin
          dly_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_HSYNC;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      S_HSYNC: begin
        if (dly_q == HS_LAST) begin
          dly_d   = '0;
          state_d = S_DATA;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      S_DATA: begin
        xfer = pixel_Ready;
        if (xfer) begin
          if (col_q != COL_LAST) begin
            col_d = col_q + COL_WIDTH'(2);
          end else if (row_q != ROW_LAST) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = S_HSYNC;
          end else begin
            // last pair of the frame: hold indices for one DONE cycle
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        dly_d   = '0;
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign vertical_Pulse   = (state_q == S_VSYNC);
  assign horizontal_Pulse = (state_q == S_DATA);
  assign pixel_Valid      = (state_q == S_DATA);
  assign busy             = (state_q != S_IDLE);
  assign done_Flag        = (state_q == S_DONE);
  assign row              = row_q;
  assign column           = col_q;

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Directed bench for frame_read_sequencer: timing model per cycle plus a
// scoreboard of expected pixel-pair addresses popped on every transfer.
module tb_frame_read_sequencer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int SD = 3;
  localparam int HD = 2;
  localparam int RW = 10;
  localparam int CW = 11;
  localparam int FRAME = 1 + SD + H * (HD + W / 2);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pixel_Ready = 1'b1;
  logic          vertical_Pulse;
  logic          horizontal_Pulse;
  logic          pixel_Valid;
  logic [RW-1:0] row;
  logic [CW-1:0] column;
  logic          busy;
  logic          done_Flag;

  int passed = 0;
  int total  = 0;
  logic [RW+CW-1:0] exp_q[$];

  always #5 clk = ~clk;

  frame_read_sequencer #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .START_DELAY (SD),
    .HSYNC_DELAY (HD),
    .ROW_WIDTH   (RW),
    .COL_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .pixel_Ready     (pixel_Ready),
    .vertical_Pulse  (vertical_Pulse),
    .horizontal_Pulse(horizontal_Pulse),
    .pixel_Valid     (pixel_Valid),
    .row             (row),
    .column          (column),
    .busy            (busy),
    .done_Flag       (done_Flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, ".vs"},    32'(vertical_Pulse),   0);
    chk({tag, ".hs"},    32'(horizontal_Pulse), 0);
    chk({tag, ".valid"}, 32'(pixel_Valid),      0);
    chk({tag, ".row"},   32'(row),              0);
    chk({tag, ".col"},   32'(column),           0);
    chk({tag, ".busy"},  32'(busy),             0);
    chk({tag, ".done"},  32'(done_Flag),        0);
  endtask

  // Caller has set start for the sampling edge; returns at the
  // falling edge of the first IDLE cycle after DONE.
  task automatic frame(input int stall, input bit poke,
                       input bit hold, input bit abort);
    int done_at;
    int stalls;
    bit in_stall;
    logic [RW+CW-1:0] e;
    done_at  = FRAME + stall;
    stalls   = 0;
    in_stall = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c += 2)
        exp_q.push_back({RW'(r), CW'(c)});
    for (int n = 1; n <= done_at + 1; n++) begin
      @(negedge clk);
      start = hold;
      if (poke && (n == 10 || n == done_at)) start = 1'b1;
      if (abort && pixel_Valid && row == 2 && column == 2) begin
        reset = 1'b1;
        #1;
        outs_zero("abort");
        repeat (3) begin
          @(negedge clk);
          chk("abort.done", 32'(done_Flag), 0);
          chk("abort.busy", 32'(busy), 0);
        end
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      chk("vsync", 32'(vertical_Pulse), 32'(n <= SD));
      chk("busy",  32'(busy),           32'(n <= done_at));
      chk("done",  32'(done_Flag),      32'(n == done_at));
      chk("hs",    32'(horizontal_Pulse), 32'(pixel_Valid));
      pixel_Ready = 1'b1;
      if (!in_stall && stalls == 0 && stall > 0 && pixel_Valid &&
          row == 1 && column == 4)
        in_stall = 1'b1;
      if (in_stall) begin
        chk("stall.row",   32'(row),         1);
        chk("stall.col",   32'(column),      4);
        chk("stall.valid", 32'(pixel_Valid), 1);
        pixel_Ready = 1'b0;
        stalls++;
        if (stalls == stall) in_stall = 1'b0;
      end
      if (pixel_Valid && pixel_Ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_xfer", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("xfer.row", 32'(row),    32'(e[RW+CW-1:CW]));
          chk("xfer.col", 32'(column), 32'(e[CW-1:0]));
        end
      end
    end
    chk("xfers_left", 32'(exp_q.size()), 0);
    chk("stall_len",  32'(stalls), 32'(stall));
    if (poke) begin
      @(negedge clk);
      start = 1'b0;
      chk("poke.busy", 32'(busy), 0);
      chk("poke.done", 32'(done_Flag), 0);
    end
  endtask

  initial begin
    #12;
    outs_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    outs_zero("post_reset");

    start = 1'b1;
    frame(0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    frame(0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    frame(5, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    frame(0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    frame(0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    frame(0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    frame(0, 1'b0, 1'b1, 1'b0);
    frame(0, 1'b0, 1'b1, 1'b0);
    frame(0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("final.busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
